// File: rtl/arith_pkg.sv
// ============================================================================
// arith_pkg : constants and types shared by the sequential multiplier/divider
// Revision  : 1.0
// ============================================================================
`default_nettype none

package arith_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Counter counts 0..w-1, so clog2(w) bits; keep at least one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

endpackage : arith_pkg

`default_nettype wire

// File: rtl/mul_16b.sv
// ============================================================================
// mul_16b : sequential shift-add unsigned multiplier, start/ready handshake
// Revision: 1.0
// ============================================================================
`default_nettype none

module mul_16b
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 start,
  output logic [2*WIDTH-1:0]   prod,
  output logic                 ready
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH:0]     acc_q,   acc_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [2*WIDTH-1:0]   prod_q,  prod_d;
  logic [WIDTH:0]       upper_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    // The carry slot acc[2W] is zero after every shift, so the add never overflows.
    upper_sum = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, mcand_q} : '0);

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          acc_d   = {{(WIDTH + 1){1'b0}}, b};
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = {1'b0, upper_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          prod_d  = acc_d[2*WIDTH-1:0];
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign prod  = prod_q;
  assign ready = (state_q == IDLE);

endmodule : mul_16b

`default_nettype wire

// File: tb/tb_mul_16b.sv
// ============================================================================
// tb_mul_16b : scoreboard bench for the sequential shift-add multiplier
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_mul_16b;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        start;
  logic [31:0] prod;
  logic        ready;

  int          vectors;
  int          miscompares;
  logic [31:0] exp_q[$];

  mul_16b #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .start (start),
    .prod  (prod),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] xx, yy;
    xx = {16'h0, x};
    yy = {16'h0, y};
    return xx * yy;
  endfunction

  // Run one operation; optionally disturb a/b/start mid-BUSY.
  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input bit disturb,
                       input string name);
    logic [31:0] old_prod, exp_v;
    int          lat;
    bit          held;
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    exp_q.push_back(model(x, y));
    old_prod = prod;
    @(posedge clk);
    #1 start = 1'b0;
    lat  = 0;
    held = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) break;
      lat++;
      if (prod !== old_prod) held = 1'b0;
      if (disturb && lat == 5) begin
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
      end
      if (disturb && lat == 7) start = 1'b0;
    end
    vectors++;
    if (lat !== 16) begin
      miscompares++;
      $display("FAIL %s latency: got %0d busy cycles, expected 16", name, lat);
    end
    vectors++;
    if (!held) begin
      miscompares++;
      $display("FAIL %s hold: prod changed during BUSY (old %h)", name, old_prod);
    end
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    vectors++;
    if (prod !== exp_v) begin
      miscompares++;
      $display("FAIL %s prod: got %h, expected %h", name, prod, exp_v);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if (ready !== 1'b1 || prod !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_idle cycle %0d: ready=%b prod=%h, expected ready=1 prod=0",
                 i, ready, prod);
      end
    end
  endtask

  task automatic test_basic();
    do_op(16'd3, 16'd5, 1'b0, "basic_3x5");
  endtask

  task automatic test_max_carry();
    do_op(16'hFFFF, 16'hFFFF, 1'b0, "max_ffff");
    do_op(16'h8000, 16'h0002, 1'b0, "carry_8000x2");
  endtask

  task automatic test_zero_ignored();
    do_op(16'h1234, 16'h0000, 1'b0, "zero_b");
    do_op(16'd7, 16'd9, 1'b1, "ignored_7x9");
  endtask

  task automatic test_back_to_back();
    int          lat, high;
    logic [31:0] exp_v;
    @(negedge clk);
    a = 16'd2; b = 16'd2; start = 1'b1;
    exp_q.push_back(model(16'd2, 16'd2));
    @(posedge clk);
    #1 a = 16'd10; b = 16'd10;
    exp_q.push_back(model(16'd10, 16'd10));
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) break;
      lat++;
    end
    vectors++;
    if (lat !== 16) begin
      miscompares++;
      $display("FAIL b2b_first latency: got %0d, expected 16", lat);
    end
    exp_v = exp_q.pop_front();
    vectors++;
    if (prod !== exp_v) begin
      miscompares++;
      $display("FAIL b2b_first prod: got %h, expected %h", prod, exp_v);
    end
    @(posedge clk);
    #1 start = 1'b0;
    high = 1;
    lat  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) break;
      lat++;
    end
    vectors++;
    if (lat !== 16 || high !== 1) begin
      miscompares++;
      $display("FAIL b2b_second latency: got %0d busy cycles, expected 16 after 1 ready cycle", lat);
    end
    exp_v = exp_q.pop_front();
    vectors++;
    if (prod !== exp_v) begin
      miscompares++;
      $display("FAIL b2b_second prod: got %h, expected %h", prod, exp_v);
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (ready !== 1'b1 || prod !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_op: ready=%b prod=%h, expected ready=1 prod=0", ready, prod);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h0123, 16'h0045, 1'b0, "after_reset");
  endtask

  task automatic test_round_trip();
    logic [15:0] x, y;
    for (int i = 0; i < 10; i++) begin
      if (i < 5) begin
        x = 16'($urandom_range(0, 255));
        y = 16'($urandom_range(1, 255));
      end else begin
        x = 16'($urandom);
        y = 16'($urandom);
      end
      do_op(x, y, 1'b0, "random");
      if (prod < 32'h10000 && y != 16'h0) begin
        vectors++;
        if ((prod[15:0] / y) !== x || (prod[15:0] % y) !== 16'h0) begin
          miscompares++;
          $display("FAIL round_trip: prod=%h / b=%h gives q=%h r=%h, expected q=%h r=0",
                   prod, y, prod[15:0] / y, prod[15:0] % y, x);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_max_carry();
    test_zero_ignored();
    test_back_to_back();
    test_reset_mid_op();
    test_round_trip();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

endmodule : tb_mul_16b

`default_nettype wire
